gabor_conv_stream: RTL and testbench
====================================

Name: gabor_conv_stream

Overview:
- Streaming, multi-orientation Gabor convolution engine, generalised from the fixed 4-orientation 5x5 design.
- Accepts raster-order unsigned pixels over a valid/ready interface and holds K-1 lines in internal line buffers.
- Applies NUM_ORIENT runtime-loadable sign-magnitude KxK kernels in parallel to each valid window.
- Emits one clipped output pixel per orientation per window, with backpressure. It sits between the image source memory and the per-orientation output stores.

Parameters:
- IMG_W, 512, frame width in pixels (>= KLEN)
- IMG_H, 512, frame height in pixels (>= KLEN)
- KLEN, 5, kernel side length (odd, 3..7)
- NUM_ORIENT, 4, number of orientation channels (1..8)
- PW, 8, pixel width (unsigned)
- CW, 11, coefficient width: bit CW-1 is the sign, bits CW-2:0 are the magnitude
- FRAC, 9, coefficient fractional bits; the result is shifted right by FRAC

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  coefficient write strobe
- cfg_orient  in  $clog2(NUM_ORIENT)  target orientation
- cfg_idx  in  $clog2(KLEN*KLEN)  tap index, row-major
- cfg_data  in  CW  sign-magnitude coefficient
- cfg_err  out  1  sticky; set by a write outside IDLE, cleared by start
- start  in  1  frame start pulse, honoured in IDLE only
- in_valid  in  1  pixel valid
- in_data  in  PW  pixel
- in_ready  out  1  pixel accept
- out_valid  out  1  result valid
- out_data  out  NUM_ORIENT*PW  orientation o occupies bits [o*PW +: PW]
- out_ready  in  1  downstream accept
- out_sof  out  1  first window of frame, qualified by out_valid
- out_eol  out  1  last window of an output row, qualified by out_valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at the end of a frame

Behaviour:
- Reset: all outputs 0; state IDLE; counters and pipeline valids cleared; coefficient RAM cleared to 0; line-buffer contents don't-care.
- FSM IDLE -> FILL on start; FILL -> RUN when pixel (row KLEN-1, col KLEN-1) is accepted; RUN -> DRAIN when pixel (IMG_H-1, IMG_W-1) is accepted; DRAIN -> IDLE once the pipeline is empty, with done pulsed for one cycle.
- cfg_we acts only in IDLE. Writes in any other state are dropped and set cfg_err.
- Handshake: a pixel transfers on in_valid && in_ready. in_ready = (state is FILL or RUN) && !stall, where stall = out_valid && !out_ready. While stalled, the whole pipeline freezes and out_data is held stable.
- Col/row counters wrap col IMG_W-1 -> 0 with row+1. A window is valid iff row >= KLEN-1 && col >= KLEN-1, giving (IMG_W-KLEN+1)*(IMG_H-KLEN+1) outputs per frame.
- Pipeline: 3 stages, registered at each.
  - S1: per-tap product pixel*magnitude, sign = coefficient sign.
  - S2: signed sum over KLEN*KLEN taps per orientation. Accumulator width ACC_W = PW + CW - 1 + $clog2(KLEN*KLEN) + 1; no wrap.
  - S3: arithmetic shift right by FRAC, truncating toward negative infinity. Negative results -> 0; results > 2^PW-1 -> 2^PW-1.
- Latency: out_valid rises 3 cycles after the accepting edge of the window's last pixel, absent stall.
- A start during FILL, RUN or DRAIN is ignored.
- Asserting rst mid-frame aborts the frame: no done, outputs return to reset values, coefficients are cleared.
- A simultaneous final-pixel accept and output stall stays in RUN until the accept completes.

Optional Feature:
- Macro GABOR_ABS_MAG_EN.
- When defined, S3 outputs saturate(|shifted sum|), which preserves negative Gabor responses as magnitude.
- When undefined, negative results clip to 0. Latency is unchanged either way.

Decomposition:
- Package gabor_pkg holds:
  - state enum (IDLE, FILL, RUN, DRAIN)
  - coef_t sign-magnitude struct
  - ACC_W as a localparam function
  - clip/saturate function
- Sub-module gabor_line_buffer: KLEN-1 circular line RAMs of IMG_W x PW, plus a KLEN x KLEN window shift register, advanced on accept.

Test Plan:
- Identity kernel, IMG_W=IMG_H=8, KLEN=5: tap 12 = +512 and all others 0 on every orientation; ramp pixel p(r,c) = 8r + c. Expect 16 outputs with out(i,j) = p(i+2, j+2), out_sof on the first, out_eol on every 4th, then done.
- Constant 200 with all 25 taps = +20: expect every output 195 on all orientations (100000 >> 9).
- Center tap = -512 with pixel 100: expect 0. With GABOR_ABS_MAG_EN defined, expect 100.
- All taps +1023 with pixel 255: expect 255, saturated from 12737.
- out_ready held low for 10 cycles mid-frame: expect out_data stable, in_ready = 0, and no lost or duplicated outputs (count = 16).
- cfg_we during RUN: expect cfg_err = 1 and the coefficient unchanged. Then rst asserted mid-frame: expect busy = 0, out_valid = 0 and no done pulse.

Source files
------------

// File: rtl/gabor_pkg.sv
// Shared types and helpers for the streaming Gabor convolution engine:
// FSM states, sign-magnitude coefficient record, accumulator sizing, clipping.
package gabor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Magnitude field sized for the widest supported coefficient (CW <= 17).
  localparam int MAG_MAX_W = 16;

  typedef struct packed {
    logic                 neg;
    logic [MAG_MAX_W-1:0] mag;
  } coef_t;

  function automatic int acc_width(input int pw, input int cw, input int klen);
    return pw + cw - 1 + $clog2(klen * klen) + 1;
  endfunction

  function automatic coef_t coef_decode(input logic [MAG_MAX_W:0] raw, input int cw);
    coef_t c;
    c.neg = raw[cw-1];
    c.mag = raw[MAG_MAX_W-1:0] & ((MAG_MAX_W'(1) << (cw - 1)) - MAG_MAX_W'(1));
    return c;
  endfunction

  // Clip a signed value into [0, 2^pw-1]; with abs_en negatives fold to magnitude.
  function automatic logic [31:0] clip_sat(input logic signed [63:0] v, input int pw,
                                           input bit abs_en);
    logic signed [63:0] m;
    logic signed [63:0] lim;
    lim = (64'sd1 <<< pw) - 64'sd1;
    if (v < 64'sd0) m = abs_en ? -v : 64'sd0;
    else            m = v;
    if (m > lim) m = lim;
    return m[31:0];
  endfunction

endpackage

// File: rtl/gabor_conv_stream_if.sv
// Pixel-in / result-out stream bundle; master is the frame source and sink,
// slave is the convolution engine.
interface gabor_conv_stream_if #(
  parameter int PW         = 8,
  parameter int NUM_ORIENT = 4
);
  logic                     in_valid;
  logic [PW-1:0]            in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [NUM_ORIENT*PW-1:0] out_data;
  logic                     out_ready;
  logic                     out_sof;
  logic                     out_eol;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol
  );
endinterface

// File: rtl/gabor_line_buffer.sv
// KLEN-1 line RAMs cascaded row to row plus a KLEN x KLEN window shift register.
// Everything advances only when a pixel is accepted; contents need no reset.
module gabor_line_buffer #(
  parameter  int IMG_W = 512,
  parameter  int KLEN  = 5,
  parameter  int PW    = 8,
  localparam int XW    = $clog2(IMG_W)
) (
  input  logic                      clk,
  input  logic                      adv,
  input  logic [XW-1:0]             col,
  input  logic [PW-1:0]             pix,
  output logic [KLEN*KLEN*PW-1:0]   win
);

  logic [PW-1:0] line_ram [KLEN-1][IMG_W];
  logic [PW-1:0] win_q    [KLEN][KLEN];
  logic [PW-1:0] col_vec  [KLEN];

  // col_vec[0] is the oldest row, col_vec[KLEN-1] the incoming pixel.
  always_comb begin
    col_vec[KLEN-1] = pix;
    for (int r = 0; r < KLEN - 1; r++) begin
      col_vec[r] = line_ram[KLEN-2-r][col];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      line_ram[0][col] <= pix;
      for (int k = 1; k < KLEN - 1; k++) begin
        line_ram[k][col] <= line_ram[k-1][col];
      end
      for (int r = 0; r < KLEN; r++) begin
        for (int c = 0; c < KLEN - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][KLEN-1] <= col_vec[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < KLEN; r++) begin
      for (int c = 0; c < KLEN; c++) begin
        win[(r*KLEN+c)*PW +: PW] = win_q[r][c];
      end
    end
  end

endmodule

// File: rtl/gabor_conv_stream.sv
// Streaming NUM_ORIENT-channel KxK Gabor convolution with valid/ready backpressure.
// Define GABOR_ABS_MAG_EN to output |response| instead of clipping negatives to 0.
module gabor_conv_stream
  import gabor_pkg::*;
#(
  parameter  int IMG_W      = 512,
  parameter  int IMG_H      = 512,
  parameter  int KLEN       = 5,
  parameter  int NUM_ORIENT = 4,
  parameter  int PW         = 8,
  parameter  int CW         = 11,
  parameter  int FRAC       = 9,
  localparam int OW         = (NUM_ORIENT > 1) ? $clog2(NUM_ORIENT) : 1,
  localparam int TW         = $clog2(KLEN * KLEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [OW-1:0]           cfg_orient,
  input  logic [TW-1:0]           cfg_idx,
  input  logic [CW-1:0]           cfg_data,
  output logic                    cfg_err,
  input  logic                    start,
  gabor_conv_stream_if.slave      strm,
  output logic                    busy,
  output logic                    done
);

  localparam int TAPS   = KLEN * KLEN;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int PROD_W = PW + CW;
  localparam int MUL_W  = PW + MAG_MAX_W;
  localparam int ACC_W  = acc_width(PW, CW, KLEN);

`ifdef GABOR_ABS_MAG_EN
  localparam bit ABS_EN = 1'b1;
`else
  localparam bit ABS_EN = 1'b0;
`endif

  function automatic logic signed [PROD_W-1:0] tap_prod(input logic [PW-1:0] px, input coef_t c);
    logic signed [PROD_W-1:0] p;
    p = $signed(PROD_W'(MUL_W'(px) * MUL_W'(c.mag)));
    return c.neg ? -p : p;
  endfunction

  function automatic logic [PW-1:0] sat_px(input logic signed [ACC_W-1:0] v);
    return PW'(clip_sat(64'(v), PW, ABS_EN));
  endfunction

  state_t state, state_nxt;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic accept, stall, last_px, fill_px, win_ok, pipe_empty, cfg_wr_ok;
  coef_t coef_ram [NUM_ORIENT][TAPS];

  logic [TAPS*PW-1:0]       win_p0;
  logic                     vld_p0, vld_p1, vld_p2, vld_p3;
  logic                     sof_p0, sof_p1, sof_p2, sof_p3;
  logic                     eol_p0, eol_p1, eol_p2, eol_p3;
  logic signed [PROD_W-1:0] prod_c  [NUM_ORIENT][TAPS];
  logic signed [PROD_W-1:0] prod_p1 [NUM_ORIENT][TAPS];
  logic signed [ACC_W-1:0]  acc_c   [NUM_ORIENT];
  logic signed [ACC_W-1:0]  acc_p2  [NUM_ORIENT];
  logic signed [ACC_W-1:0]  sh_c    [NUM_ORIENT];
  logic [NUM_ORIENT*PW-1:0] px_c;
  logic [NUM_ORIENT*PW-1:0] out_p3;

  assign stall      = vld_p3 && !strm.out_ready;
  assign accept     = strm.in_valid && strm.in_ready;
  assign last_px    = (row == YW'(IMG_H - 1)) && (col == XW'(IMG_W - 1));
  assign fill_px    = (row == YW'(KLEN - 1)) && (col == XW'(KLEN - 1));
  assign win_ok     = (row >= YW'(KLEN - 1)) && (col >= XW'(KLEN - 1));
  assign pipe_empty = !vld_p0 && !vld_p1 && !vld_p2 && !vld_p3;
  assign cfg_wr_ok  = cfg_we && (state == IDLE) && (int'(cfg_orient) < NUM_ORIENT) &&
                      (int'(cfg_idx) < TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    strm.in_ready = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = FILL;
      FILL: begin
        strm.in_ready = !stall;
        if (accept && last_px)      state_nxt = DRAIN;
        else if (accept && fill_px) state_nxt = RUN;
      end
      RUN: begin
        strm.in_ready = !stall;
        if (accept && last_px) state_nxt = DRAIN;
      end
      DRAIN: if (pipe_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      cfg_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == DRAIN) && pipe_empty;
      if (state == IDLE && start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col == XW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + YW'(1);
        end else begin
          col <= col + XW'(1);
        end
      end
      if (state == IDLE && start)       cfg_err <= 1'b0;
      else if (cfg_we && state != IDLE) cfg_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NUM_ORIENT; o++) begin
        for (int t = 0; t < TAPS; t++) coef_ram[o][t] <= '0;
      end
    end else if (cfg_wr_ok) begin
      coef_ram[cfg_orient][cfg_idx] <= coef_decode((MAG_MAX_W+1)'(cfg_data), CW);
    end
  end

  // Stage 0: window register, loaded on every accepted pixel
  gabor_line_buffer #(.IMG_W(IMG_W), .KLEN(KLEN), .PW(PW)) u_lb (
    .clk (clk),
    .adv (accept),
    .col (col),
    .pix (strm.in_data),
    .win (win_p0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vld_p0, vld_p1, vld_p2, vld_p3} <= '0;
      {sof_p0, sof_p1, sof_p2, sof_p3} <= '0;
      {eol_p0, eol_p1, eol_p2, eol_p3} <= '0;
    end else if (!stall) begin
      vld_p0 <= accept && win_ok;
      sof_p0 <= fill_px;
      eol_p0 <= (col == XW'(IMG_W - 1));
      {vld_p1, vld_p2, vld_p3} <= {vld_p0, vld_p1, vld_p2};
      {sof_p1, sof_p2, sof_p3} <= {sof_p0, sof_p1, sof_p2};
      {eol_p1, eol_p2, eol_p3} <= {eol_p0, eol_p1, eol_p2};
    end
  end

  // Stage 1: signed per-tap products
  always_comb begin
    for (int o = 0; o < NUM_ORIENT; o++) begin
      for (int t = 0; t < TAPS; t++) begin
        prod_c[o][t] = tap_prod(win_p0[t*PW +: PW], coef_ram[o][t]);
      end
    end
  end

  // Stage 2: full-width tap sum per orientation
  always_comb begin
    for (int o = 0; o < NUM_ORIENT; o++) begin
      acc_c[o] = '0;
      for (int t = 0; t < TAPS; t++) acc_c[o] = acc_c[o] + ACC_W'(prod_p1[o][t]);
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int o = 0; o < NUM_ORIENT; o++) begin
        for (int t = 0; t < TAPS; t++) prod_p1[o][t] <= prod_c[o][t];
        acc_p2[o] <= acc_c[o];
      end
    end
  end

  // Stage 3: floor shift, clip, pack
  always_comb begin
    for (int o = 0; o < NUM_ORIENT; o++) begin
      sh_c[o]            = acc_p2[o] >>> FRAC;
      px_c[o*PW +: PW]   = sat_px(sh_c[o]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   out_p3 <= '0;
    else if (!stall && vld_p2) out_p3 <= px_c;
  end

  assign strm.out_valid = vld_p3;
  assign strm.out_data  = out_p3;
  assign strm.out_sof   = sof_p3;
  assign strm.out_eol   = eol_p3;

endmodule

// File: tb/tb_gabor_conv_stream.sv
// Directed bench for gabor_conv_stream on an 8x8 frame with 5x5 kernels.
module tb_gabor_conv_stream;
  localparam int IMG_W = 8, IMG_H = 8, KLEN = 5, NUM_ORIENT = 4, PW = 8, CW = 11, FRAC = 9;
  localparam int NOUT = 16;
  localparam logic [CW-1:0] POS512 = 11'h200, NEG512 = 11'h600, POS256 = 11'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0, start = 1'b0;
  logic [1:0] cfg_orient = '0;
  logic [4:0] cfg_idx = '0;
  logic [CW-1:0] cfg_data = '0;
  logic cfg_err, busy, done;

  gabor_conv_stream_if #(.PW(PW), .NUM_ORIENT(NUM_ORIENT)) strm ();

  gabor_conv_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KLEN(KLEN), .NUM_ORIENT(NUM_ORIENT),
                      .PW(PW), .CW(CW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_orient(cfg_orient), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .start(start), .strm(strm), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, done_cnt = 0;
  logic [31:0] cap_data[$];
  logic [1:0]  cap_flags[$];

  always @(negedge clk) begin
    if (strm.out_valid && strm.out_ready) begin
      cap_data.push_back(strm.out_data);
      cap_flags.push_back({strm.out_sof, strm.out_eol});
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input int o, input int t, input logic [CW-1:0] v);
    cfg_we = 1'b1; cfg_orient = 2'(o); cfg_idx = 5'(t); cfg_data = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_kernel(input int o, input int tap, input logic [CW-1:0] v_tap,
                             input logic [CW-1:0] v_other);
    for (int t = 0; t < KLEN*KLEN; t++) write_coef(o, t, (t == tap) ? v_tap : v_other);
  endtask

  task automatic start_frame();
    cap_data.delete(); cap_flags.delete();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic feed_pixels(input bit ramp, input int cval, input int first, input int last,
                             output bit ok);
    int w;
    ok = 1'b1;
    for (int i = first; i <= last; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = ramp ? PW'(i) : PW'(cval);
      w = 0;
      @(negedge clk);
      while (!strm.in_ready && w < 300) begin @(negedge clk); w++; end
      if (!strm.in_ready) begin ok = 1'b0; break; end
      @(posedge clk); #1;
    end
    strm.in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    int base;
    base = done_cnt;
    got = 1'b0;
    for (int w = 0; w < 300 && !got; w++) begin
      @(negedge clk);
      if (done_cnt > base) got = 1'b1;
    end
    tick();
  endtask

  function automatic logic [31:0] rep4(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b, b, b, b};
  endfunction

  task automatic test_reset();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %b want 0", cfg_err); else passed++;
    checks++; if (strm.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", strm.in_ready); else passed++;
    checks++; if (strm.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", strm.out_valid); else passed++;
    checks++; if (strm.out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", strm.out_data); else passed++;
    checks++; if ({strm.out_sof, strm.out_eol} !== 2'b00) $display("FAIL reset_sof_eol got %b want 00", {strm.out_sof, strm.out_eol}); else passed++;
  endtask

  task automatic test_identity();
    bit ok, got;
    for (int o = 0; o < NUM_ORIENT; o++) load_kernel(o, 12, POS512, '0);
    start_frame();
    checks++; if (busy !== 1'b1) $display("FAIL ident_busy got %b want 1", busy); else passed++;
    feed_pixels(1'b1, 0, 0, 63, ok);
    wait_done(got);
    checks++; if (!(ok && got)) $display("FAIL ident_done got ok=%0d done=%0d want 1/1", ok, got); else passed++;
    checks++; if (cap_data.size() != NOUT) $display("FAIL ident_count got %0d want %0d", cap_data.size(), NOUT); else passed++;
    for (int k = 0; k < cap_data.size() && k < NOUT; k++) begin
      checks++;
      if (cap_data[k] !== rep4(8*(k/4 + 2) + (k%4 + 2)))
        $display("FAIL ident_data[%0d] got %h want %h", k, cap_data[k], rep4(8*(k/4+2) + (k%4+2)));
      else passed++;
      checks++;
      if (cap_flags[k] !== {k == 0, (k % 4) == 3})
        $display("FAIL ident_sof_eol[%0d] got %b want %b", k, cap_flags[k], {k == 0, (k % 4) == 3});
      else passed++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL ident_idle got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_orient();
    bit ok, got;
    logic [31:0] e;
    int a, b;
    load_kernel(0, 12, POS512, '0);
    load_kernel(1, 12, NEG512, '0);
    load_kernel(2, 0, POS512, '0);
    load_kernel(3, 24, POS256, '0);
    start_frame();
    feed_pixels(1'b1, 0, 0, 63, ok);
    wait_done(got);
    checks++; if (cap_data.size() != NOUT || !ok || !got) $display("FAIL orient_count got %0d want %0d", cap_data.size(), NOUT); else passed++;
    for (int k = 0; k < cap_data.size() && k < NOUT; k++) begin
      a = k / 4; b = k % 4;
      e[7:0]   = 8'(8*(a+2) + b + 2);
`ifdef GABOR_ABS_MAG_EN
      e[15:8]  = 8'(8*(a+2) + b + 2);
`else
      e[15:8]  = 8'd0;
`endif
      e[23:16] = 8'(8*a + b);
      e[31:24] = 8'((8*(a+4) + b + 4) / 2);
      checks++;
      if (cap_data[k] !== e) $display("FAIL orient_data[%0d] got %h want %h", k, cap_data[k], e);
      else passed++;
    end
  endtask

  task automatic test_const(input string name, input int tap, input logic [CW-1:0] vt,
                            input logic [CW-1:0] vo, input int pix, input int expv);
    bit ok, got;
    for (int o = 0; o < NUM_ORIENT; o++) load_kernel(o, tap, vt, vo);
    start_frame();
    feed_pixels(1'b0, pix, 0, 63, ok);
    wait_done(got);
    checks++; if (cap_data.size() != NOUT || !ok || !got) $display("FAIL %s_count got %0d want %0d", name, cap_data.size(), NOUT); else passed++;
    for (int k = 0; k < cap_data.size(); k++) begin
      checks++;
      if (cap_data[k] !== rep4(expv)) $display("FAIL %s_data[%0d] got %h want %h", name, k, cap_data[k], rep4(expv));
      else passed++;
    end
  endtask

  task automatic test_back_to_back_stall();
    bit ok, got;
    logic [31:0] hold;
    int w2;
    for (int o = 0; o < NUM_ORIENT; o++) load_kernel(o, 12, POS512, '0);
    start_frame();
    fork
      feed_pixels(1'b1, 0, 0, 63, ok);
      begin
        w2 = 0;
        while (cap_data.size() < 5 && w2 < 300) begin @(negedge clk); w2++; end
        @(posedge clk); #1; strm.out_ready = 1'b0;
        w2 = 0;
        @(negedge clk);
        while (!strm.out_valid && w2 < 50) begin @(negedge clk); w2++; end
        hold = strm.out_data;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checks++;
          if (strm.out_data !== hold || strm.in_ready !== 1'b0 || strm.out_valid !== 1'b1)
            $display("FAIL stall_hold[%0d] got data=%h in_ready=%b out_valid=%b want data=%h in_ready=0 out_valid=1",
                     k, strm.out_data, strm.in_ready, strm.out_valid, hold);
          else passed++;
        end
        @(posedge clk); #1; strm.out_ready = 1'b1;
      end
    join
    wait_done(got);
    checks++; if (cap_data.size() != NOUT || !ok || !got) $display("FAIL stall_count got %0d want %0d", cap_data.size(), NOUT); else passed++;
    for (int k = 0; k < cap_data.size() && k < NOUT; k++) begin
      checks++;
      if (cap_data[k] !== rep4(8*(k/4 + 2) + (k%4 + 2)))
        $display("FAIL stall_data[%0d] got %h want %h", k, cap_data[k], rep4(8*(k/4+2) + (k%4+2)));
      else passed++;
    end
  endtask

  task automatic test_cfg_err_rst();
    bit ok, got;
    int base;
    for (int o = 0; o < NUM_ORIENT; o++) load_kernel(o, 12, POS512, '0);
    start_frame();
    feed_pixels(1'b1, 0, 0, 39, ok);
    start = 1'b1;
    write_coef(0, 12, '0);
    start = 1'b0;
    checks++; if (cfg_err !== 1'b1) $display("FAIL cfg_err_set got %b want 1", cfg_err); else passed++;
    feed_pixels(1'b1, 0, 40, 63, ok);
    wait_done(got);
    checks++; if (cap_data.size() != NOUT || !ok || !got) $display("FAIL cfg_count got %0d want %0d", cap_data.size(), NOUT); else passed++;
    for (int k = 0; k < cap_data.size() && k < NOUT; k++) begin
      checks++;
      if (cap_data[k] !== rep4(8*(k/4 + 2) + (k%4 + 2)))
        $display("FAIL cfg_keep[%0d] got %h want %h", k, cap_data[k], rep4(8*(k/4+2) + (k%4+2)));
      else passed++;
    end
    checks++; if (cfg_err !== 1'b1) $display("FAIL cfg_err_sticky got %b want 1", cfg_err); else passed++;
    start_frame();
    checks++; if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear got %b want 0", cfg_err); else passed++;
    feed_pixels(1'b1, 0, 0, 39, ok);
    base = done_cnt;
    rst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || strm.out_valid !== 1'b0 || strm.in_ready !== 1'b0 || strm.out_data !== 32'h0)
      $display("FAIL rst_abort got busy=%b out_valid=%b in_ready=%b data=%h want 0/0/0/0",
               busy, strm.out_valid, strm.in_ready, strm.out_data);
    else passed++;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    checks++; if (done_cnt != base) $display("FAIL rst_no_done got %0d pulses want 0", done_cnt - base); else passed++;
    start_frame();
    feed_pixels(1'b0, 200, 0, 63, ok);
    wait_done(got);
    checks++; if (cap_data.size() != NOUT || !ok || !got) $display("FAIL rst_count got %0d want %0d", cap_data.size(), NOUT); else passed++;
    for (int k = 0; k < cap_data.size(); k++) begin
      checks++;
      if (cap_data[k] !== 32'h0) $display("FAIL rst_coef_clear[%0d] got %h want 0", k, cap_data[k]);
      else passed++;
    end
  endtask

  initial begin
    strm.in_valid  = 1'b0;
    strm.in_data   = '0;
    strm.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    test_reset();
    test_identity();
    test_orient();
    test_const("const200", 0, 11'd20, 11'd20, 200, 195);
`ifdef GABOR_ABS_MAG_EN
    test_const("neg_center", 12, NEG512, 11'd0, 100, 100);
`else
    test_const("neg_center", 12, NEG512, 11'd0, 100, 0);
`endif
    test_const("saturate", 0, 11'd1023, 11'd1023, 255, 255);
    test_back_to_back_stall();
    test_cfg_err_rst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
